// File: rtl/nic_pe_port.sv
// Processor-side NIC port: one-flit TX buffer and RX buffer between CPU and router.
// Optional NIC_RX_TWO_DEEP_EN turns the RX buffer into a 2-entry FIFO.
module nic_pe_port (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  addr,
    input  logic [63:0] d_in,
    output logic [63:0] d_out,
    input  logic        nicEn,
    input  logic        nicWrEn,
    output logic        net_so,
    input  logic        net_ro,
    output logic [63:0] net_do,
    input  logic        net_polarity,
    input  logic        net_si,
    output logic        net_ri,
    input  logic [63:0] net_di
);

    localparam logic [1:0] A_RXB = 2'b00;
    localparam logic [1:0] A_RXS = 2'b01;
    localparam logic [1:0] A_TXB = 2'b10;
    localparam logic [1:0] A_TXS = 2'b11;

    logic        rd_en;
    logic        wr_en;
    logic [63:0] tx_buf;
    logic        tx_full;
    logic        tx_load;
    logic        rx_push;
    logic        rx_pop;
    logic        rx_avail;
    logic [63:0] rx_head;
    logic [63:0] rd_data;

    assign rd_en = nicEn & ~nicWrEn;
    assign wr_en = nicEn & nicWrEn;

    // Send only on the router's cycle matching the flit's virtual channel.
    assign net_so  = tx_full & net_ro & (net_polarity == tx_buf[63]);
    assign net_do  = tx_buf;
    assign tx_load = wr_en & (addr == A_TXB) & ~tx_full;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_buf  <= '0;
            tx_full <= 1'b0;
        end else if (tx_load) begin
            tx_buf  <= d_in;
            tx_full <= 1'b1;
        end else if (net_so) begin
            tx_full <= 1'b0;
        end
    end

`ifdef NIC_RX_TWO_DEEP_EN
    logic [63:0] rx_q0;
    logic [63:0] rx_q1;
    logic [1:0]  rx_cnt;

    assign net_ri   = (rx_cnt != 2'd2);
    assign rx_avail = (rx_cnt != 2'd0);
    assign rx_head  = rx_q0;
    assign rx_push  = net_si & net_ri;
    assign rx_pop   = rd_en & (addr == A_RXB) & rx_avail;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_q0  <= '0;
            rx_q1  <= '0;
            rx_cnt <= 2'd0;
        end else begin
            // On pop the head refills from entry 1, or straight from the
            // router when only one entry was held and a flit arrives.
            if (rx_pop) begin
                rx_q0 <= (rx_push && rx_cnt == 2'd1) ? net_di : rx_q1;
            end else if (rx_push) begin
                if (rx_cnt == 2'd0) begin
                    rx_q0 <= net_di;
                end else begin
                    rx_q1 <= net_di;
                end
            end
            case ({rx_push, rx_pop})
                2'b10:   rx_cnt <= rx_cnt + 2'd1;
                2'b01:   rx_cnt <= rx_cnt - 2'd1;
                default: rx_cnt <= rx_cnt;
            endcase
        end
    end
`else
    logic [63:0] rx_buf;
    logic        rx_full;

    assign net_ri   = ~rx_full;
    assign rx_avail = rx_full;
    assign rx_head  = rx_buf;
    assign rx_push  = net_si & net_ri;
    assign rx_pop   = rd_en & (addr == A_RXB) & rx_full;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_buf  <= '0;
            rx_full <= 1'b0;
        end else if (rx_push) begin
            rx_buf  <= net_di;
            rx_full <= 1'b1;
        end else if (rx_pop) begin
            rx_full <= 1'b0;
        end
    end
`endif

    always_comb begin
        rd_data = '0;
        case (addr)
            A_RXB:   rd_data = rx_head;
            A_RXS:   rd_data = {63'b0, rx_avail};
            A_TXB:   rd_data = tx_buf;
            A_TXS:   rd_data = {63'b0, tx_full};
            default: rd_data = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d_out <= '0;
        end else if (rd_en) begin
            d_out <= rd_data;
        end
    end

endmodule

// File: tb/tb_nic_pe_port.sv
// Self-checking bench for nic_pe_port; scoreboard queues hold expected reads and sends.
`timescale 1ns/1ps
module tb_nic_pe_port;

`ifdef NIC_RX_TWO_DEEP_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    logic        clk;
    logic        reset;
    logic [1:0]  addr;
    logic [63:0] d_in;
    logic [63:0] d_out;
    logic        nicEn;
    logic        nicWrEn;
    logic        net_so;
    logic        net_ro;
    logic [63:0] net_do;
    logic        net_polarity;
    logic        net_si;
    logic        net_ri;
    logic [63:0] net_di;

    int checks;
    int fails;
    logic [63:0] rd_q[$];
    logic [63:0] tx_q[$];
    logic [63:0] exp;

    nic_pe_port dut (
        .clk(clk), .reset(reset), .addr(addr), .d_in(d_in), .d_out(d_out),
        .nicEn(nicEn), .nicWrEn(nicWrEn), .net_so(net_so), .net_ro(net_ro),
        .net_do(net_do), .net_polarity(net_polarity), .net_si(net_si),
        .net_ri(net_ri), .net_di(net_di)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_read(input logic [1:0] a);
        @(negedge clk);
        addr = a; nicEn = 1'b1; nicWrEn = 1'b0;
        @(negedge clk);
        nicEn = 1'b0;
    endtask

    task automatic do_write(input logic [1:0] a, input logic [63:0] d);
        @(negedge clk);
        addr = a; d_in = d; nicEn = 1'b1; nicWrEn = 1'b1;
        @(negedge clk);
        nicEn = 1'b0; nicWrEn = 1'b0;
    endtask

    task automatic push_flit(input logic [63:0] d);
        @(negedge clk);
        net_si = 1'b1; net_di = d;
        @(negedge clk);
        net_si = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        reset = 1'b1; net_ro = 1'b1; net_polarity = 1'b0;
        #1;
        checks++; if (d_out !== 64'd0) begin fails++; $display("FAIL rst_dout: got %h want 0", d_out); end
        checks++; if (net_ri !== 1'b1) begin fails++; $display("FAIL rst_ri: got %b want 1", net_ri); end
        checks++; if (net_so !== 1'b0) begin fails++; $display("FAIL rst_so: got %b want 0", net_so); end
        checks++; if (net_do !== 64'd0) begin fails++; $display("FAIL rst_do: got %h want 0", net_do); end
        net_ro = 1'b0;
    endtask

    task automatic test_tx_send;
        int so_cnt;
        int bad_pol;
        logic [63:0] f;
        so_cnt = 0; bad_pol = 0;
        f = 64'h8000_0000_1111_1111;
        net_ro = 1'b1; net_polarity = 1'b0;
        tx_q.push_back(f);
        do_write(2'b10, f);
        #1;
        checks++; if (net_so !== 1'b0) begin fails++; $display("FAIL tx_pol0: got %b want 0", net_so); end
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            net_polarity = i[0];
            #1;
            if (net_so === 1'b1) begin
                so_cnt++;
                if (net_polarity !== 1'b1) bad_pol++;
                if (tx_q.size() == 0) exp = 'x; else exp = tx_q.pop_front();
                checks++; if (net_do !== exp) begin fails++; $display("FAIL tx_data: got %h want %h", net_do, exp); end
            end
        end
        checks++; if (so_cnt != 1) begin fails++; $display("FAIL tx_once: got %0d sends want 1", so_cnt); end
        checks++; if (bad_pol != 0) begin fails++; $display("FAIL tx_polarity: got %0d wrong-polarity sends want 0", bad_pol); end
        net_ro = 1'b0;
        rd_q.push_back(64'd0);
        do_read(2'b11);
        exp = rd_q.pop_front();
        checks++; if (d_out !== exp) begin fails++; $display("FAIL tx_stat_after: got %h want %h", d_out, exp); end
    endtask

    task automatic test_tx_drop;
        int so_cnt;
        logic [63:0] a, b, c, d;
        a = 64'h0123_0001_AAAA_AAAA;
        b = 64'h0456_0002_BBBB_BBBB;
        c = 64'h0000_0003_CCCC_CCCC;
        d = 64'h0000_0004_DDDD_0000;
        so_cnt = 0;
        net_ro = 1'b0; net_polarity = 1'b0;
        tx_q.push_back(a);
        do_write(2'b10, a);
        do_write(2'b10, b);
        rd_q.push_back(a);
        do_read(2'b10);
        exp = rd_q.pop_front();
        checks++; if (d_out !== exp) begin fails++; $display("FAIL tx_keep_a: got %h want %h", d_out, exp); end
        rd_q.push_back(64'd1);
        do_read(2'b11);
        exp = rd_q.pop_front();
        checks++; if (d_out !== exp) begin fails++; $display("FAIL tx_full_stat: got %h want %h", d_out, exp); end
        checks++; if (net_so !== 1'b0) begin fails++; $display("FAIL tx_ro0: got %b want 0", net_so); end
        @(negedge clk);
        net_ro = 1'b1; net_polarity = 1'b1;
        #1;
        checks++; if (net_so !== 1'b0) begin fails++; $display("FAIL tx_polmis: got %b want 0", net_so); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            net_polarity = i[0];
            #1;
            if (net_so === 1'b1) begin
                so_cnt++;
                if (tx_q.size() == 0) exp = 'x; else exp = tx_q.pop_front();
                checks++; if (net_do !== exp) begin fails++; $display("FAIL tx_drop_data: got %h want %h", net_do, exp); end
            end
        end
        checks++; if (so_cnt != 1) begin fails++; $display("FAIL tx_drop_once: got %0d sends want 1", so_cnt); end
        net_ro = 1'b0; net_polarity = 1'b0;
        tx_q.push_back(c);
        do_write(2'b10, c);
        addr = 2'b10; d_in = d; nicEn = 1'b1; nicWrEn = 1'b1; net_ro = 1'b1;
        #1;
        checks++; if (net_so !== 1'b1) begin fails++; $display("FAIL tx_same_so: got %b want 1", net_so); end
        exp = tx_q.pop_front();
        checks++; if (net_do !== exp) begin fails++; $display("FAIL tx_same_do: got %h want %h", net_do, exp); end
        @(negedge clk);
        nicEn = 1'b0; nicWrEn = 1'b0; net_ro = 1'b0;
        rd_q.push_back(64'd0);
        do_read(2'b11);
        exp = rd_q.pop_front();
        checks++; if (d_out !== exp) begin fails++; $display("FAIL tx_same_stat: got %h want %h", d_out, exp); end
        rd_q.push_back(c);
        do_read(2'b10);
        exp = rd_q.pop_front();
        checks++; if (d_out !== exp) begin fails++; $display("FAIL tx_same_buf: got %h want %h", d_out, exp); end
    endtask

    task automatic test_rx;
        logic [63:0] f;
        f = 64'h0000_0101_DDDD_DDDD;
        @(negedge clk);
        net_si = 1'b1; net_di = f;
        #1;
        checks++; if (net_ri !== 1'b1) begin fails++; $display("FAIL rx_ri_pre: got %b want 1", net_ri); end
        @(negedge clk);
        net_si = 1'b0;
        #1;
        checks++; if (net_ri !== (DEPTH == 2)) begin fails++; $display("FAIL rx_ri_full: got %b want %b", net_ri, DEPTH == 2); end
        rd_q.push_back(64'd1);
        do_read(2'b01);
        exp = rd_q.pop_front();
        checks++; if (d_out !== exp) begin fails++; $display("FAIL rx_stat1: got %h want %h", d_out, exp); end
        rd_q.push_back(f);
        do_read(2'b00);
        exp = rd_q.pop_front();
        checks++; if (d_out !== exp) begin fails++; $display("FAIL rx_data: got %h want %h", d_out, exp); end
        #1;
        checks++; if (net_ri !== 1'b1) begin fails++; $display("FAIL rx_ri_back: got %b want 1", net_ri); end
        rd_q.push_back(64'd0);
        do_read(2'b01);
        exp = rd_q.pop_front();
        checks++; if (d_out !== exp) begin fails++; $display("FAIL rx_stat0: got %h want %h", d_out, exp); end
    endtask

    task automatic test_rx_overrun;
        logic [63:0] m[$];
        logic [63:0] e;
        for (int k = 0; k < DEPTH; k++) begin
            e = 64'h0000_0200_EEEE_0000 | 64'(k);
            m.push_back(e);
            push_flit(e);
        end
        @(negedge clk);
        net_si = 1'b1; net_di = 64'h8000_0300_CCCC_CCCC;
        #1;
        checks++; if (net_ri !== 1'b0) begin fails++; $display("FAIL ovr_ri: got %b want 0", net_ri); end
        repeat (2) @(negedge clk);
        net_si = 1'b0;
        while (m.size() > 0) begin
            rd_q.push_back(m.pop_front());
            do_read(2'b00);
            exp = rd_q.pop_front();
            checks++; if (d_out !== exp) begin fails++; $display("FAIL ovr_keep: got %h want %h", d_out, exp); end
        end
        rd_q.push_back(64'd0);
        do_read(2'b01);
        exp = rd_q.pop_front();
        checks++; if (d_out !== exp) begin fails++; $display("FAIL ovr_stat: got %h want %h", d_out, exp); end
    endtask

    task automatic test_rd_push_same_edge;
        logic [63:0] m[$];
        logic [63:0] g;
        for (int k = 0; k < DEPTH; k++) begin
            g = 64'h4000_0500_9999_0000 | 64'(k);
            m.push_back(g);
            push_flit(g);
        end
        @(negedge clk);
        addr = 2'b00; nicEn = 1'b1; nicWrEn = 1'b0;
        net_si = 1'b1; net_di = 64'h0000_0600_7777_7777;
        #1;
        checks++; if (net_ri !== 1'b0) begin fails++; $display("FAIL same_ri: got %b want 0", net_ri); end
        @(negedge clk);
        nicEn = 1'b0; net_si = 1'b0;
        exp = m.pop_front();
        checks++; if (d_out !== exp) begin fails++; $display("FAIL same_pop: got %h want %h", d_out, exp); end
        while (m.size() > 0) begin
            rd_q.push_back(m.pop_front());
            do_read(2'b00);
            exp = rd_q.pop_front();
            checks++; if (d_out !== exp) begin fails++; $display("FAIL same_rest: got %h want %h", d_out, exp); end
        end
        rd_q.push_back(64'd0);
        do_read(2'b01);
        exp = rd_q.pop_front();
        checks++; if (d_out !== exp) begin fails++; $display("FAIL same_stat: got %h want %h", d_out, exp); end
    endtask

    task automatic test_back_to_back;
        logic [63:0] m[$];
        logic [63:0] x, y;
        x = 64'h2000_0700_1234_5678;
        y = 64'hA000_0800_8765_4321;
        m.push_back(x);
        if (DEPTH == 2) m.push_back(y);
        @(negedge clk);
        net_si = 1'b1; net_di = x;
        #1;
        checks++; if (net_ri !== 1'b1) begin fails++; $display("FAIL b2b_ri0: got %b want 1", net_ri); end
        @(negedge clk);
        net_di = y;
        #1;
        checks++; if (net_ri !== (DEPTH == 2)) begin fails++; $display("FAIL b2b_ri1: got %b want %b", net_ri, DEPTH == 2); end
        @(negedge clk);
        net_si = 1'b0;
        #1;
        checks++; if (net_ri !== 1'b0) begin fails++; $display("FAIL b2b_ri2: got %b want 0", net_ri); end
        while (m.size() > 0) begin
            rd_q.push_back(m.pop_front());
            do_read(2'b00);
            exp = rd_q.pop_front();
            checks++; if (d_out !== exp) begin fails++; $display("FAIL b2b_order: got %h want %h", d_out, exp); end
        end
        rd_q.push_back(64'd0);
        do_read(2'b01);
        exp = rd_q.pop_front();
        checks++; if (d_out !== exp) begin fails++; $display("FAIL b2b_stat: got %h want %h", d_out, exp); end
    endtask

    task automatic test_hold;
        logic [63:0] k;
        k = 64'hFEED_0042_0000_00AB;
        net_ro = 1'b0;
        do_write(2'b11, 64'd1);
        do_write(2'b00, '1);
        do_write(2'b01, '1);
        rd_q.push_back(64'd0);
        do_read(2'b11);
        exp = rd_q.pop_front();
        checks++; if (d_out !== exp) begin fails++; $display("FAIL wr11_ignored: got %h want %h", d_out, exp); end
        rd_q.push_back(64'd0);
        do_read(2'b01);
        exp = rd_q.pop_front();
        checks++; if (d_out !== exp) begin fails++; $display("FAIL wr0x_ignored: got %h want %h", d_out, exp); end
        tx_q.push_back(k);
        do_write(2'b10, k);
        rd_q.push_back(k);
        do_read(2'b10);
        exp = rd_q.pop_front();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            addr = 2'(i);
        end
        @(negedge clk);
        checks++; if (d_out !== exp) begin fails++; $display("FAIL hold_dout: got %h want %h", d_out, exp); end
    endtask

    task automatic test_async_reset;
        push_flit(64'h0000_0900_5555_5555);
        net_ro = 1'b1; net_polarity = 1'b1;
        #1;
        checks++; if (net_so !== 1'b1) begin fails++; $display("FAIL ar_pre_so: got %b want 1", net_so); end
        checks++; if (net_ri !== (DEPTH == 2)) begin fails++; $display("FAIL ar_pre_ri: got %b want %b", net_ri, DEPTH == 2); end
        #1;
        reset = 1'b0;
        tx_q.delete();
        #1;
        checks++; if (net_so !== 1'b0) begin fails++; $display("FAIL ar_so: got %b want 0", net_so); end
        checks++; if (net_ri !== 1'b1) begin fails++; $display("FAIL ar_ri: got %b want 1", net_ri); end
        checks++; if (d_out !== 64'd0) begin fails++; $display("FAIL ar_dout: got %h want 0", d_out); end
        checks++; if (net_do !== 64'd0) begin fails++; $display("FAIL ar_do: got %h want 0", net_do); end
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++; if (net_so !== 1'b0) begin fails++; $display("FAIL ar_post_so: got %b want 0", net_so); end
        net_ro = 1'b0;
        rd_q.push_back(64'd0);
        do_read(2'b11);
        exp = rd_q.pop_front();
        checks++; if (d_out !== exp) begin fails++; $display("FAIL ar_txstat: got %h want %h", d_out, exp); end
        rd_q.push_back(64'd0);
        do_read(2'b01);
        exp = rd_q.pop_front();
        checks++; if (d_out !== exp) begin fails++; $display("FAIL ar_rxstat: got %h want %h", d_out, exp); end
    endtask

    initial begin
        checks = 0; fails = 0;
        reset = 1'b0; addr = 2'b00; d_in = '0; nicEn = 1'b0; nicWrEn = 1'b0;
        net_ro = 1'b0; net_polarity = 1'b0; net_si = 1'b0; net_di = '0;
        test_reset();
        test_tx_send();
        test_tx_drop();
        test_rx();
        test_rx_overrun();
        test_rd_push_same_edge();
        test_back_to_back();
        test_hold();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/nic_pe_port.md
NIC_PE_PORT -- requirements
Module: nic_pe_port

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port addr, input, 2, processor register select: 00 RX buffer, 01 RX status, 10 TX buffer, 11 TX status.
REQ-004 SHALL have port d_in, input, 64, processor write data.
REQ-005 SHALL have port d_out, output, 64, processor read data, registered.
REQ-006 SHALL have port nicEn, input, 1, processor access strobe.
REQ-007 SHALL have port nicWrEn, input, 1, write (1) / read (0) qualifier for nicEn.
REQ-008 SHALL have port net_so, output, 1, send strobe to router pesi.
REQ-009 SHALL have port net_ro, input, 1, router peri: router can accept a flit.
REQ-010 SHALL have port net_do, output, 64, flit to router pedi.
REQ-011 SHALL have port net_polarity, input, 1, router even/odd cycle indicator.
REQ-012 SHALL have port net_si, input, 1, router peso: flit valid from router.
REQ-013 SHALL have port net_ri, output, 1, ready to router pero.
REQ-014 SHALL have port net_di, input, 64, flit from router pedo.

Function
REQ-015 Flit format SHALL be: [63] VC, [62:61] direction, [60:56] reserved, [55:48] hop counts, [47:32] source, [31:0] payload; the block SHALL NOT modify any field.
REQ-016 TX buffer SHALL be one 64-bit entry plus a TX-full flag.
REQ-017 Write to addr 10 with TX-full=0 SHALL load d_in and set TX-full on the same edge; with TX-full=1 the write SHALL be dropped.
REQ-018 net_so SHALL be 1 exactly when TX-full=1, net_ro=1 and net_polarity equals buffered bit 63; net_do SHALL always show the TX buffer.
REQ-019 On an edge where net_so=1, TX-full SHALL clear; a same-edge write to 10 SHALL be dropped, because the write check uses pre-edge TX-full.
REQ-020 RX buffer SHALL be one 64-bit entry plus an RX-full flag; net_ri SHALL equal ~RX-full (combinational).
REQ-021 On an edge with net_si=1 and net_ri=1, net_di SHALL be captured and RX-full set; net_si while net_ri=0 SHALL be ignored.
REQ-022 Read (nicEn=1, nicWrEn=0) SHALL update d_out on the next edge: addr 00 -> RX buffer, 01 -> {63'b0,RX-full}, 10 -> TX buffer, 11 -> {63'b0,TX-full}.
REQ-023 Read of addr 00 with RX-full=1 SHALL clear RX-full on that edge; a same-edge net_si SHALL be ignored because net_ri was 0.
REQ-024 With nicEn=0, d_out SHALL hold its value; writes to 00, 01 and 11 SHALL have no effect.
REQ-025 TX and RX paths SHALL operate independently in the same cycle.

Reset
REQ-026 reset=0 SHALL immediately clear TX-full, RX-full, both buffers and d_out; net_so SHALL be 0 and net_ri SHALL be 1 while in reset.
REQ-027 Reset mid-transfer SHALL discard any buffered TX and RX flit without emitting it.

Configuration
REQ-028 Macro NIC_RX_TWO_DEEP_EN SHALL, when defined, replace the RX buffer with a 2-entry FIFO.
- Defined: net_ri=0 only when both entries are full; addr 00 returns the oldest entry and pops it; addr 01 bit0 = not-empty.
- Simultaneous push and pop on a full FIFO SHALL be ignored, because net_ri was 0.
REQ-029 When NIC_RX_TWO_DEEP_EN is undefined, RX behaviour SHALL be as REQ-020..023.

Verification
REQ-030 Write 0x8000_0000_1111_1111 to 10 with net_ro=1 -> net_so asserts only in a cycle with net_polarity=1, for exactly one cycle; TX status then reads 0.
REQ-031 Write A to 10, hold net_ro=0, then write B to 10 -> the second write is dropped; after net_ro=1 and matching polarity, net_do=A is sent once.
REQ-032 net_si=1 with net_di=0x0000_0101_DDDD_DDDD -> net_ri falls next cycle; read 01 returns 1; read 00 returns the flit; net_ri then returns to 1.
REQ-033 Drive net_si with flit C while RX-full, without reading -> C is not captured; the earlier flit is preserved.
REQ-034 Assert reset=0 asynchronously while TX-full=1 and RX-full=1 -> both flags clear immediately, net_so=0, net_ri=1, and d_out=0.
REQ-035 With NIC_RX_TWO_DEEP_EN defined, send two flits back-to-back -> both are accepted; net_ri=0; reads return them in arrival order.
